// File: rtl/fetch_stage.sv
// Fetch stage: program counter with next-PC selection plus the IF/ID pipeline register.
// Also tracks a sticky misaligned-redirect flag and a count of instructions handed to decode.
module fetch_stage #(
    parameter int unsigned      ADDRESS_WIDTH = 32,
    parameter int unsigned      DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR    = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
    input  logic [DATA_WIDTH-1:0]    imem_rd_i,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    output logic [DATA_WIDTH-1:0]    id_instr_o,
    output logic [ADDRESS_WIDTH-1:0] id_pc_o,
    output logic [ADDRESS_WIDTH-1:0] id_pc_plus4_o,
    output logic                     id_valid_o,
    output logic                     misalign_err_o,
    output logic [31:0]              fetch_count_o
);

    localparam logic [ADDRESS_WIDTH-1:0] PcStep = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0]    id_instr_q, id_instr_d;
    logic [ADDRESS_WIDTH-1:0] id_pc_q, id_pc_d;
    logic [ADDRESS_WIDTH-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic                     id_valid_q, id_valid_d;
    logic                     misalign_q, misalign_d;
    logic [31:0]              fetch_count_q, fetch_count_d;
    logic                     bubble;
    logic                     capture;

    // Wraps silently at the top of the address space.
    assign pc_plus4 = pc_q + PcStep;

    // Redirect squashes the wrong-path instruction even when the hazard unit is stalling.
    assign bubble  = flush_i | redirect_i;
    assign capture = ~bubble & ~stall_i;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_target_i[ADDRESS_WIDTH-1:2], 2'b00};
        end else if (!stall_i) begin
            pc_d = pc_plus4;
        end
    end

    always_comb begin
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;
        if (bubble) begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (capture) begin
            id_instr_d    = imem_rd_i;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_comb begin
        misalign_d = misalign_q;
        if (redirect_i && (redirect_target_i[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= PcStep;
            id_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr_o    = pc_q;
    assign id_instr_o     = id_instr_q;
    assign id_pc_o        = id_pc_q;
    assign id_pc_plus4_o  = id_pc_plus4_q;
    assign id_valid_o     = id_valid_q;
    assign misalign_err_o = misalign_q;
    assign fetch_count_o  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run, all checked against a
// cycle-level reference model of the fetch rules driven by a synthetic ROM.
module tb_fetch_stage;

    localparam logic [31:0] RV  = 32'hBFC00000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_target_i = '0;
    logic [31:0] imem_rd_i;
    logic [31:0] imem_addr_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc_plus4_o;
    logic        id_valid_o;
    logic        misalign_err_o;
    logic [31:0] fetch_count_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_cnt;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .redirect_i       (redirect_i),
        .redirect_target_i(redirect_target_i),
        .imem_rd_i        (imem_rd_i),
        .imem_addr_o      (imem_addr_o),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o),
        .id_pc_plus4_o    (id_pc_plus4_o),
        .id_valid_o       (id_valid_o),
        .misalign_err_o   (misalign_err_o),
        .fetch_count_o    (fetch_count_o)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == RV) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign imem_rd_i = rom(imem_addr_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("imem_addr", imem_addr_o, m_pc);
        chk("id_instr", id_instr_o, m_instr);
        chk("id_pc", id_pc_o, m_idpc);
        chk("id_pc_plus4", id_pc_plus4_o, m_idpc4);
        chk("id_valid", 32'(id_valid_o), 32'(m_valid));
        chk("misalign", 32'(misalign_err_o), 32'(m_mis));
        chk("fetch_count", fetch_count_o, m_cnt);
    endtask

    // One clock: drive at negedge, advance the model at the edge, compare just after it.
    task automatic step(input logic r, input logic st, input logic fl, input logic rd,
                        input logic [31:0] tg);
        @(negedge clk);
        rst = r; stall_i = st; flush_i = fl; redirect_i = rd; redirect_target_i = tg;
        @(posedge clk);
        if (r) begin
            m_pc = RV; m_instr = NOP; m_idpc = 0; m_idpc4 = 4;
            m_valid = 0; m_mis = 0; m_cnt = 0;
        end else begin
            if (rd || fl) begin
                m_instr = NOP; m_valid = 0;
            end else if (!st) begin
                m_instr = rom(m_pc); m_idpc = m_pc; m_idpc4 = m_pc + 4;
                m_valid = 1; m_cnt = m_cnt + 1;
            end
            if (rd && (tg % 4 != 0)) m_mis = 1;
            if (rd) m_pc = tg - (tg % 4);
            else if (!st) m_pc = m_pc + 4;
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [31:0] frz_instr, frz_pc;

        // Reset held for two edges
        step(1, 0, 0, 0, 0);
        chk("reset_addr", imem_addr_o, RV);
        step(1, 1, 1, 1, 32'h3);
        chk("reset_addr2", imem_addr_o, RV);
        chk("reset_mis", 32'(misalign_err_o), 0);

        // First fetch after release
        step(0, 0, 0, 0, 0);
        chk("first_instr", id_instr_o, 32'h00500093);
        chk("first_pc", id_pc_o, RV);
        chk("first_pc4", id_pc_plus4_o, 32'hBFC00004);
        chk("first_valid", 32'(id_valid_o), 1);
        chk("first_cnt", fetch_count_o, 1);
        chk("seq_addr1", imem_addr_o, 32'hBFC00004);
        step(0, 0, 0, 0, 0);
        chk("seq_addr2", imem_addr_o, 32'hBFC00008);

        // Stall three cycles at 0xBFC00008
        frz_instr = id_instr_o;
        frz_pc    = id_pc_o;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            chk("stall_addr", imem_addr_o, 32'hBFC00008);
            chk("stall_instr", id_instr_o, frz_instr);
            chk("stall_pc", id_pc_o, frz_pc);
            chk("stall_cnt", fetch_count_o, 2);
        end
        step(0, 0, 0, 0, 0);
        chk("resume_pc", id_pc_o, 32'hBFC00008);
        step(0, 0, 0, 0, 0);
        chk("seq_addr4", imem_addr_o, 32'hBFC00010);
        chk("seq_cnt4", fetch_count_o, 4);

        // Redirect: one bubble then the target
        step(0, 0, 0, 1, 32'hBFC00040);
        chk("redir_valid", 32'(id_valid_o), 0);
        chk("redir_instr", id_instr_o, NOP);
        chk("redir_addr", imem_addr_o, 32'hBFC00040);
        step(0, 0, 0, 0, 0);
        chk("redir_tgt_pc", id_pc_o, 32'hBFC00040);
        chk("redir_tgt_valid", 32'(id_valid_o), 1);

        // Stall + flush + misaligned redirect together
        step(0, 1, 1, 1, 32'hBFC00102);
        chk("combo_addr", imem_addr_o, 32'hBFC00100);
        chk("combo_valid", 32'(id_valid_o), 0);
        chk("combo_mis", 32'(misalign_err_o), 1);
        // Flush under stall, no redirect: bubble while PC holds
        step(0, 1, 1, 0, 0);
        chk("flstall_addr", imem_addr_o, 32'hBFC00100);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("mis_sticky", 32'(misalign_err_o), 1);
        end

        // Wrap at the top of the address space
        step(0, 0, 0, 1, 32'hFFFFFFFC);
        chk("wrap_pre", imem_addr_o, 32'hFFFFFFFC);
        step(0, 0, 0, 0, 0);
        chk("wrap_addr", imem_addr_o, 32'h00000000);
        chk("wrap_pc4", id_pc_plus4_o, 32'h00000000);

        // Reset in the middle of a stall
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("mid_rst_addr", imem_addr_o, RV);
        chk("mid_rst_instr", id_instr_o, NOP);
        chk("mid_rst_pc", id_pc_o, 0);
        chk("mid_rst_pc4", id_pc_plus4_o, 4);
        chk("mid_rst_valid", 32'(id_valid_o), 0);
        chk("mid_rst_mis", 32'(misalign_err_o), 0);
        chk("mid_rst_cnt", fetch_count_o, 0);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tg;
            tg = ($urandom_range(0, 3) == 0) ? $urandom() : RV + 32'($urandom_range(0, 255));
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), tg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Program-counter and IF/ID pipeline-register block that drives the address port of the instruction ROM and consumes its asynchronous read data. It holds the PC and selects the next PC: sequential, redirected (branch/jump from EX), or held on stall. It registers the fetched instruction and its PC for the decode stage, and inserts NOP bubbles on flush or redirect. It also keeps a sticky misaligned-target flag and a fetch counter.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction-memory address
DATA_WIDTH, 32, instruction width
RESET_VECTOR, 32'hBFC00000, PC value after reset (base of ROM)
NOP_INSTR, 32'h00000013, instruction injected as a bubble (addi x0,x0,0)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous active-high reset
stall_i  in  1  hazard unit: hold PC and IF/ID register
flush_i  in  1  squash IF/ID contents (insert bubble)
redirect_i  in  1  taken branch/jump from EX
redirect_target_i  in  ADDRESS_WIDTH  branch/jump target address
imem_rd_i  in  DATA_WIDTH  instruction ROM read data (combinational from imem_addr_o)
imem_addr_o  out  ADDRESS_WIDTH  instruction ROM address, equals current PC
id_instr_o  out  DATA_WIDTH  registered instruction to decode
id_pc_o  out  ADDRESS_WIDTH  PC of id_instr_o
id_pc_plus4_o  out  ADDRESS_WIDTH  id_pc_o + 4 (for JAL/JALR link)
id_valid_o  out  1  id_instr_o is a real fetched instruction
misalign_err_o  out  1  sticky: a redirect target had bits [1:0] != 0
fetch_count_o  out  32  count of instructions delivered to decode

Behaviour:
- Reset (rst=1 at a rising edge) applies to every output and overrides all other inputs:
  - pc <= RESET_VECTOR
  - id_instr_o <= NOP_INSTR
  - id_pc_o <= 0
  - id_pc_plus4_o <= 4
  - id_valid_o <= 0
  - misalign_err_o <= 0
  - fetch_count_o <= 0
- imem_addr_o = pc, combinational. Zero-latency ROM: the instruction is captured at the same edge that advances the PC.
- PC update priority, highest first:
  - rst
  - redirect_i: pc <= {redirect_target_i[AW-1:2], 2'b00}
  - stall_i: pc holds
  - otherwise: pc <= pc + 4, modulo 2^ADDRESS_WIDTH. Wrap from 32'hFFFFFFFC to 0 is silent.
- IF/ID update priority, highest first:
  - rst
  - flush_i or redirect_i: bubble (id_instr_o=NOP_INSTR, id_valid_o=0; id_pc_o and id_pc_plus4_o unchanged)
  - stall_i: all IF/ID registers hold
  - otherwise: capture id_instr_o=imem_rd_i, id_pc_o=pc, id_pc_plus4_o=pc+4, id_valid_o=1
- Redirect beats stall. With stall_i=1 and redirect_i=1 together, the PC loads the target and IF/ID takes a bubble.
- flush_i with stall_i and no redirect: the IF/ID bubble is inserted and the PC still holds.
- misalign_err_o sets when redirect_i=1 and redirect_target_i[1:0] != 0 (including while stalled). It stays set until rst.
- fetch_count_o increments by 1 on each edge where IF/ID captures a valid instruction. It wraps modulo 2^32.
- Redirect penalty: the first edge with redirect_i=1 issues a bubble. The next edge captures the target instruction with id_valid_o=1.

Test Plan:
- Reset then run: rst for 2 cycles, ROM word at 0xBFC00000 = 0x00500093. Required response:
  - imem_addr_o=0xBFC00000 during reset
  - first edge after release: id_instr_o=0x00500093, id_pc_o=0xBFC00000, id_pc_plus4_o=0xBFC00004, id_valid_o=1, fetch_count_o=1
- Sequential fetch, 4 edges from reset: imem_addr_o steps 0xBFC00004, ...08, ...0C, ...10; fetch_count_o=4.
- Stall: assert stall_i for 3 cycles at PC=0xBFC00008. Required response:
  - imem_addr_o, id_instr_o, id_pc_o and fetch_count_o frozen for all 3 cycles
  - after release, capture resumes at 0xBFC00008
- Redirect: redirect_i=1 with target 0xBFC00040 for one cycle. Required response:
  - next cycle: id_valid_o=0, id_instr_o=0x00000013, imem_addr_o=0xBFC00040
  - following edge: id_pc_o=0xBFC00040, id_valid_o=1
- Simultaneous stall_i=1, flush_i=1, redirect_i=1 with target 0xBFC00102. Required response:
  - pc=0xBFC00100
  - bubble inserted
  - misalign_err_o=1 and stays 1 until rst
- Wrap and mid-run reset: force redirect to 0xFFFFFFFC then run, giving next imem_addr_o=0x00000000. Then assert rst mid-stall; all outputs return to their reset values at that edge.
